csr_io_arbiter: RTL and testbench

- Shares the processor's memory-mapped CSR I/O block (inputs in0–in2, outputs out0–out2) between two requesters: requester 0 is the processor core, requester 1 is the debug/test host.
- Arbitrates with round-robin priority and serialises accesses through a small FSM.
- Decodes TinyRV1 CSR numbers, owns the out0–out2 registers, and returns read data or an error on a val/rdy response channel.

---
 rtl/csr_io_arbiter.sv | 132 +++++++++++++
 tb/tb_csr_io_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/csr_io_arbiter.sv
`default_nettype none
// ============================================================================
// csr_io_arbiter: round-robin arbiter sharing the TinyRV1 CSR I/O block
// between the core (req 0) and the debug host (req 1).   Revision: 1.0
// ============================================================================
module csr_io_arbiter #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] OUT_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_val,
  output logic [1:0]    req_rdy,
  input  logic [11:0]   req_addr0,
  input  logic [11:0]   req_addr1,
  input  logic          req_wen0,
  input  logic          req_wen1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic          resp_val,
  input  logic          resp_rdy,
  output logic          resp_id,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [15:0]   access_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t        state;
  logic          ptr;
  logic          gnt;
  logic          accept;
  logic [11:0]   sel_addr;
  logic          sel_wen;
  logic [DW-1:0] sel_wdata;
  logic          is_in;
  logic          is_out;
  logic [1:0]    idx;
  logic [DW-1:0] rd_val;
  logic          acc_err;

  // Under contention the pointer decides; a lone requester always wins.
  always_comb begin
    gnt = 1'b0;
    if (req_val == 2'b11) gnt = ptr;
    else                  gnt = req_val[1];
    accept  = (state == IDLE) && (|req_val);
    req_rdy = 2'b00;
    if (accept) req_rdy = gnt ? 2'b10 : 2'b01;
  end

  assign sel_addr  = gnt ? req_addr1  : req_addr0;
  assign sel_wen   = gnt ? req_wen1   : req_wen0;
  assign sel_wdata = gnt ? req_wdata1 : req_wdata0;

  always_comb begin
    is_in  = 1'b0;
    is_out = 1'b0;
    idx    = 2'd0;
    rd_val = '0;
    case (sel_addr)
      12'hFC2: begin is_in  = 1'b1; idx = 2'd0; rd_val = in0;  end
      12'hFC3: begin is_in  = 1'b1; idx = 2'd1; rd_val = in1;  end
      12'hFC4: begin is_in  = 1'b1; idx = 2'd2; rd_val = in2;  end
      12'h7C2: begin is_out = 1'b1; idx = 2'd0; rd_val = out0; end
      12'h7C3: begin is_out = 1'b1; idx = 2'd1; rd_val = out1; end
      12'h7C4: begin is_out = 1'b1; idx = 2'd2; rd_val = out2; end
      default: ;
    endcase
    acc_err = !(is_in || is_out) || (sel_wen && is_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      resp_val     <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      out0         <= OUT_RST;
      out1         <= OUT_RST;
      out2         <= OUT_RST;
      access_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RESP;
            ptr      <= ~gnt;
            resp_val <= 1'b1;
            resp_id  <= gnt;
            resp_err <= acc_err;
            if (acc_err) begin
              resp_data <= '0;
            end else if (sel_wen) begin
              resp_data <= sel_wdata;
              case (idx)
                2'd0:    out0 <= sel_wdata;
                2'd1:    out1 <= sel_wdata;
                default: out2 <= sel_wdata;
              endcase
            end else begin
              resp_data <= rd_val;
            end
          end
        end
        RESP: begin
          // No bypass: the next request is only considered back in IDLE.
          if (resp_rdy) begin
            state        <= IDLE;
            resp_val     <= 1'b0;
            access_count <= access_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_io_arbiter.sv
`default_nettype none
// Directed self-checking bench for csr_io_arbiter.
module tb_csr_io_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [11:0] req_addr0, req_addr1;
  logic        req_wen0, req_wen1;
  logic [31:0] req_wdata0, req_wdata1;
  logic        resp_val, resp_rdy, resp_id, resp_err;
  logic [31:0] resp_data;
  logic [31:0] in0, in1, in2, out0, out1, out2;
  logic [15:0] access_count;

  int n_assert = 0;
  int n_fail   = 0;

  csr_io_arbiter #(.DW(32), .OUT_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wen0(req_wen0), .req_wen1(req_wen1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .in0(in0), .in1(in1), .in2(in2),
    .out0(out0), .out1(out1), .out2(out2),
    .access_count(access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_val = 2'b00; resp_rdy = 1'b0;
    req_addr0 = 12'h0; req_addr1 = 12'h0; req_wen0 = 1'b0; req_wen1 = 1'b0;
    req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    in0 = 32'hA0A0_0000; in1 = 32'h1234_5678; in2 = 32'h0C0C_0C0C;
    #1;
    chk("rst_resp_val", resp_val, 0);
    chk("rst_out0", out0, 32'h0);
    chk("rst_count", access_count, 0);
    chk("rst_resp_data", resp_data, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // single write from requester 0
    req_val = 2'b01; req_addr0 = 12'h7C2; req_wen0 = 1'b1; req_wdata0 = 32'hAB;
    #1 chk("wr_req_rdy", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    chk("wr_out0", out0, 32'hAB);
    chk("wr_resp_val", resp_val, 1);
    chk("wr_resp_id", resp_id, 0);
    chk("wr_resp_data", resp_data, 32'hAB);
    chk("wr_resp_err", resp_err, 0);
    chk("wr_rdy_resp", req_rdy, 2'b00);
    resp_rdy = 1'b1;
    tick();
    chk("wr_done_val", resp_val, 0);
    chk("wr_count", access_count, 1);

    // read in1 from requester 1
    req_val = 2'b10; req_addr1 = 12'hFC3; req_wen1 = 1'b0;
    #1 chk("rd_req_rdy", req_rdy, 2'b10);
    tick();
    req_val = 2'b00;
    chk("rd_resp_id", resp_id, 1);
    chk("rd_resp_data", resp_data, 32'h1234_5678);
    chk("rd_resp_err", resp_err, 0);
    tick();
    chk("rd_count", access_count, 2);

    // contention: both held, pointer at 0 -> grants 0,1,0,1
    req_addr0 = 12'h7C3; req_wen0 = 1'b1; req_wdata0 = 32'h11;
    req_addr1 = 12'h7C4; req_wen1 = 1'b1; req_wdata1 = 32'h22;
    req_val = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_req_rdy", req_rdy, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      chk("rr_resp_val", resp_val, 1);
      chk("rr_resp_id", resp_id, k % 2);
      chk("rr_rdy_busy", req_rdy, 2'b00);
      tick();
    end
    req_val = 2'b00;
    chk("rr_out1", out1, 32'h11);
    chk("rr_out2", out2, 32'h22);
    chk("rr_count", access_count, 6);

    // write to read-only input -> error, no change
    req_val = 2'b01; req_addr0 = 12'hFC2; req_wen0 = 1'b1; req_wdata0 = 32'hFF;
    tick();
    req_val = 2'b00;
    chk("ero_err", resp_err, 1);
    chk("ero_data", resp_data, 32'h0);
    chk("ero_out0", out0, 32'hAB);
    tick();

    // unmapped read -> error
    req_val = 2'b10; req_addr1 = 12'h123; req_wen1 = 1'b0;
    tick();
    req_val = 2'b00;
    chk("unm_err", resp_err, 1);
    chk("unm_data", resp_data, 32'h0);
    tick();
    chk("err_count", access_count, 8);

    // backpressure: response held while resp_rdy=0
    resp_rdy = 1'b0;
    req_val = 2'b01; req_addr0 = 12'h7C2; req_wen0 = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_val", resp_val, 1);
      chk("bp_id", resp_id, 0);
      chk("bp_data", resp_data, 32'hAB);
      chk("bp_err", resp_err, 0);
      chk("bp_rdy", req_rdy, 2'b00);
      tick();
    end
    chk("bp_count_hold", access_count, 8);
    resp_rdy = 1'b1; req_val = 2'b00;
    tick();
    chk("bp_done_val", resp_val, 0);
    chk("bp_count", access_count, 9);

    // async reset in the middle of RESP (pointer left at 1 beforehand)
    resp_rdy = 1'b0;
    req_val = 2'b01; req_addr0 = 12'h7C3; req_wen0 = 1'b1; req_wdata0 = 32'h55;
    tick();
    req_val = 2'b00;
    chk("ar_pre_val", resp_val, 1);
    chk("ar_pre_out1", out1, 32'h55);
    #2 rst = 1'b0;
    #1;
    chk("ar_resp_val", resp_val, 0);
    chk("ar_out0", out0, 32'h0);
    chk("ar_out1", out1, 32'h0);
    chk("ar_out2", out2, 32'h0);
    chk("ar_count", access_count, 0);
    chk("ar_resp_data", resp_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_post_val", resp_val, 0);
    req_val = 2'b11;
    #1 chk("ar_ptr_reset", req_rdy, 2'b01);
    req_val = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
